// File: rtl/clkgen_divider.sv
// clkgen_divider: lock-qualified reset sequencer plus NUM_CH runtime-programmable
// fractional clock-enable dividers, all in the single system clock domain.
//
// Ports
//   in_clk       system clock (the only clock)
//   in_reset_n   asynchronous active-low reset
//   in_locked    DCM lock status; gates out_reset
//   cfg_valid/cfg_ready/cfg_ch/cfg_div/cfg_frac/cfg_enable
//                config write handshake (write fires on cfg_valid & cfg_ready)
//   out_tick     one-cycle tick per channel (held high for div=1, frac=0)
//   out_clk      per-channel divided clock, toggles in each tick cycle
//   out_active   per-channel registered run condition
//   out_reset    active-high synchronous system reset

// One divider lane. Counter runs 0..N-1 with N = div + carry, where carry is
// the carry-out of the fractional accumulator taken at each wrap.
module clkgen_divider_ch #(
  parameter int DIV_WIDTH  = 16,
  parameter int FRAC_WIDTH = 4,
  parameter int INIT_DIV   = 54,
  parameter int INIT_FRAC  = 0,
  parameter int INIT_EN    = 1
) (
  input  logic                  in_clk,
  input  logic                  in_reset_n,
  input  logic                  reset_nxt,   // value out_reset takes at this edge
  input  logic                  wr,          // accepted write aimed at this lane
  input  logic [DIV_WIDTH-1:0]  wr_div,
  input  logic [FRAC_WIDTH-1:0] wr_frac,
  input  logic                  wr_enable,
  output logic                  tick,
  output logic                  div_clk,
  output logic                  active
);

  logic                  en, en_n;
  logic [DIV_WIDTH-1:0]  div, div_n, use_div, last, cnt, cnt_inc, shd_div;
  logic [FRAC_WIDTH-1:0] frac, frac_n, use_frac, acc, shd_frac;
  logic [FRAC_WIDTH:0]   sum;
  logic                  carry, carry_n, shd_vld;
  logic                  wr_shadow, wr_now, run_n, wrap, tick_wrap, tick_inc;

  always_comb begin
    // A keep-running write to a live lane is deferred to the next wrap so the
    // current period and out_clk phase are untouched; anything else lands now.
    wr_shadow = wr && active && !reset_nxt && wr_enable && (wr_div != '0);
    wr_now    = wr && !wr_shadow;
    en_n      = wr_now ? wr_enable : en;
    div_n     = wr_now ? wr_div    : div;
    frac_n    = wr_now ? wr_frac   : frac;
    run_n     = !reset_nxt && en_n && (div_n != '0);
    last      = div - DIV_WIDTH'(1) + DIV_WIDTH'(carry);
    cnt_inc   = cnt + DIV_WIDTH'(1);
    wrap      = (cnt == last);
    // A shadow write arriving on the wrap edge itself applies right away.
    use_div   = wr_shadow ? wr_div  : (shd_vld ? shd_div  : div);
    use_frac  = wr_shadow ? wr_frac : (shd_vld ? shd_frac : frac);
    sum       = {1'b0, acc} + {1'b0, use_frac};
    // div all-ones has no room for +1, so the carry is dropped there.
    carry_n   = sum[FRAC_WIDTH] && (use_div != '1);
    tick_wrap = (use_div == DIV_WIDTH'(1)) && !carry_n;
    tick_inc  = (cnt_inc == last);
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      en       <= 1'(INIT_EN);
      div      <= DIV_WIDTH'(INIT_DIV);
      frac     <= FRAC_WIDTH'(INIT_FRAC);
      shd_vld  <= 1'b0;
      shd_div  <= '0;
      shd_frac <= '0;
      cnt      <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      active   <= 1'b0;
      tick     <= 1'b0;
      div_clk  <= 1'b0;
    end else begin
      en   <= en_n;
      div  <= div_n;
      frac <= frac_n;
      if (!run_n) begin
        active  <= 1'b0;
        cnt     <= '0;
        acc     <= '0;
        carry   <= 1'b0;
        shd_vld <= 1'b0;
        tick    <= 1'b0;
        div_clk <= 1'b0;
      end else if (!active) begin
        // start: counter is 0 in the first running cycle, first period has no carry
        active  <= 1'b1;
        cnt     <= '0;
        acc     <= '0;
        carry   <= 1'b0;
        shd_vld <= 1'b0;
        tick    <= (div_n == DIV_WIDTH'(1));
        div_clk <= (div_n == DIV_WIDTH'(1));
      end else if (wrap) begin
        cnt     <= '0;
        div     <= use_div;
        frac    <= use_frac;
        acc     <= sum[FRAC_WIDTH-1:0];
        carry   <= carry_n;
        shd_vld <= 1'b0;
        tick    <= tick_wrap;
        div_clk <= div_clk ^ tick_wrap;
      end else begin
        cnt     <= cnt_inc;
        tick    <= tick_inc;
        div_clk <= div_clk ^ tick_inc;
        if (wr_shadow) begin
          shd_vld  <= 1'b1;
          shd_div  <= wr_div;
          shd_frac <= wr_frac;
        end
      end
    end
  end

endmodule

module clkgen_divider #(
  parameter int NUM_CH       = 2,
  parameter int CH_WIDTH     = 1,
  parameter int DIV_WIDTH    = 16,
  parameter int FRAC_WIDTH   = 4,
  parameter int INIT_DIV     = 54,
  parameter int INIT_FRAC    = 0,
  parameter int INIT_EN      = 1,
  parameter int RESET_CYCLES = 4
) (
  input  logic                  in_clk,
  input  logic                  in_reset_n,
  input  logic                  in_locked,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_WIDTH-1:0]   cfg_ch,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [FRAC_WIDTH-1:0] cfg_frac,
  input  logic                  cfg_enable,
  output logic [NUM_CH-1:0]     out_tick,
  output logic [NUM_CH-1:0]     out_clk,
  output logic [NUM_CH-1:0]     out_active,
  output logic                  out_reset
);

  localparam int LW = $clog2(RESET_CYCLES + 1);

  logic [LW-1:0] lock_cnt;
  logic          reset_nxt;
  logic          cfg_fire;

  // Lanes see the upcoming out_reset so they stop on the same edge it rises
  // and start on the same edge it falls.
  always_comb begin
    reset_nxt = out_reset;
    if (!in_locked)
      reset_nxt = 1'b1;
    else if (out_reset && (lock_cnt == LW'(RESET_CYCLES - 1)))
      reset_nxt = 1'b0;
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      lock_cnt  <= '0;
      out_reset <= 1'b1;
    end else begin
      out_reset <= reset_nxt;
      if (!in_locked)
        lock_cnt <= '0;
      else if (out_reset)
        lock_cnt <= lock_cnt + LW'(1);
    end
  end

  assign cfg_ready = !out_reset;
  assign cfg_fire  = cfg_valid && cfg_ready;

  // Writes to cfg_ch >= NUM_CH still handshake but match no lane.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkgen_divider_ch #(
      .DIV_WIDTH (DIV_WIDTH),
      .FRAC_WIDTH(FRAC_WIDTH),
      .INIT_DIV  (INIT_DIV),
      .INIT_FRAC (INIT_FRAC),
      .INIT_EN   (INIT_EN)
    ) u_ch (
      .in_clk    (in_clk),
      .in_reset_n(in_reset_n),
      .reset_nxt (reset_nxt),
      .wr        (cfg_fire && (cfg_ch == CH_WIDTH'(g))),
      .wr_div    (cfg_div),
      .wr_frac   (cfg_frac),
      .wr_enable (cfg_enable),
      .tick      (out_tick[g]),
      .div_clk   (out_clk[g]),
      .active    (out_active[g])
    );
  end

endmodule

// File: tb/tb_clkgen_divider.sv
// Bench for clkgen_divider: a cycle model of the divider rules (countdown to
// the next tick, integer fractional accumulator) checked against the DUT every
// cycle, plus directed literal checks of the headline timings.
module tb_clkgen_divider;

  localparam int NCH = 2;
  localparam int CHW = 2;
  localparam int DW  = 16;
  localparam int FW  = 4;
  localparam int RC  = 4;

  logic           in_clk = 1'b0;
  logic           in_reset_n, in_locked;
  logic           cfg_valid, cfg_ready, cfg_enable;
  logic [CHW-1:0] cfg_ch;
  logic [DW-1:0]  cfg_div;
  logic [FW-1:0]  cfg_frac;
  logic [NCH-1:0] out_tick, out_clk, out_active;
  logic           out_reset;

  clkgen_divider #(
    .NUM_CH(NCH), .CH_WIDTH(CHW), .DIV_WIDTH(DW), .FRAC_WIDTH(FW),
    .INIT_DIV(54), .INIT_FRAC(0), .INIT_EN(1), .RESET_CYCLES(RC)
  ) dut (
    .in_clk(in_clk), .in_reset_n(in_reset_n), .in_locked(in_locked),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_frac(cfg_frac), .cfg_enable(cfg_enable),
    .out_tick(out_tick), .out_clk(out_clk), .out_active(out_active),
    .out_reset(out_reset)
  );

  always #5 in_clk = ~in_clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_rst;
  int m_lock;
  int m_en[NCH], m_div[NCH], m_frac[NCH];
  int m_pend[NCH], m_pdiv[NCH], m_pfrac[NCH];
  int m_act[NCH], m_left[NCH], m_acc[NCH];
  bit m_tick[NCH], m_clk[NCH];

  initial begin : model
    bit acc_ok, nrst, wr, shd, run;
    int sum, c;
    forever begin
      @(posedge in_clk or negedge in_reset_n);
      if (!in_reset_n) begin
        m_rst = 1; m_lock = 0;
        for (int i = 0; i < NCH; i++) begin
          m_en[i] = 1; m_div[i] = 54; m_frac[i] = 0; m_pend[i] = 0;
          m_pdiv[i] = 0; m_pfrac[i] = 0; m_act[i] = 0; m_left[i] = 0;
          m_acc[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
        end
      end else begin
        acc_ok = cfg_valid && !m_rst;
        if (!in_locked) begin
          m_lock = 0; nrst = 1;
        end else begin
          nrst = m_rst;
          if (m_rst) begin
            m_lock++;
            if (m_lock >= RC) nrst = 0;
          end
        end
        for (int i = 0; i < NCH; i++) begin
          wr  = acc_ok && (int'(cfg_ch) == i);
          shd = wr && m_act[i] != 0 && !nrst && cfg_enable && cfg_div != 0;
          if (wr && !shd) begin
            m_en[i] = cfg_enable; m_div[i] = cfg_div; m_frac[i] = cfg_frac;
          end
          run = !nrst && m_en[i] != 0 && m_div[i] != 0;
          if (!run) begin
            m_act[i] = 0; m_left[i] = 0; m_acc[i] = 0; m_pend[i] = 0;
            m_tick[i] = 0; m_clk[i] = 0;
          end else if (m_act[i] == 0) begin
            m_act[i] = 1; m_acc[i] = 0; m_pend[i] = 0;
            m_left[i] = m_div[i] - 1;
            m_tick[i] = (m_left[i] == 0);
            m_clk[i] = m_tick[i];
          end else if (m_tick[i]) begin
            // new period starts: pick up any deferred config first
            if (shd) begin
              m_div[i] = cfg_div; m_frac[i] = cfg_frac;
            end else if (m_pend[i] != 0) begin
              m_div[i] = m_pdiv[i]; m_frac[i] = m_pfrac[i];
            end
            m_pend[i] = 0;
            sum = m_acc[i] + m_frac[i];
            c = (sum >= (1 << FW) && m_div[i] != (1 << DW) - 1) ? 1 : 0;
            m_acc[i] = sum % (1 << FW);
            m_left[i] = m_div[i] + c - 1;
            m_tick[i] = (m_left[i] == 0);
            m_clk[i] = m_clk[i] ^ m_tick[i];
          end else begin
            m_left[i]--;
            if (shd) begin
              m_pend[i] = 1; m_pdiv[i] = cfg_div; m_pfrac[i] = cfg_frac;
            end
            m_tick[i] = (m_left[i] == 0);
            m_clk[i] = m_clk[i] ^ m_tick[i];
          end
        end
        m_rst = nrst;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    int et, ec, ea;
    forever begin
      @(negedge in_clk);
      if (chk_on) begin
        et = 0; ec = 0; ea = 0;
        for (int i = 0; i < NCH; i++) begin
          et |= int'(m_tick[i]) << i;
          ec |= int'(m_clk[i]) << i;
          ea |= (m_act[i] != 0 ? 1 : 0) << i;
        end
        chk("model_out_reset", int'(out_reset), int'(m_rst));
        chk("model_cfg_ready", int'(cfg_ready), int'(!m_rst));
        chk("model_out_tick", int'(out_tick), et);
        chk("model_out_clk", int'(out_clk), ec);
        chk("model_out_active", int'(out_active), ea);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge in_clk);
  endtask

  task automatic cfg_wr(input int ch, input int d, input int f, input bit e);
    cfg_valid = 1; cfg_ch = CHW'(ch); cfg_div = DW'(d); cfg_frac = FW'(f); cfg_enable = e;
    @(negedge in_clk);
    cfg_valid = 0;
  endtask

  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin
      @(negedge in_clk);
      n++;
    end while (!out_tick[ch] && n < 5000);
    if (!out_tick[ch]) begin
      total++; bad++;
      $display("FAIL tick_timeout ch%0d: no tick within %0d cycles", ch, n);
    end
  endtask

  task automatic wait_release(output int n);
    n = 0;
    do begin
      @(negedge in_clk);
      n++;
    end while (out_reset && n < 100);
  endtask

  int n, sum, cnt;
  bit c0;

  initial begin
    in_reset_n = 0; in_locked = 1; cfg_valid = 0; cfg_ch = '0;
    cfg_div = '0; cfg_frac = '0; cfg_enable = 0;
    cyc(3);
    chk_on = 1;
    chk("rst_out_reset", int'(out_reset), 1);
    chk("rst_cfg_ready", int'(cfg_ready), 0);
    chk("rst_out_tick", int'(out_tick), 0);
    chk("rst_out_clk", int'(out_clk), 0);
    chk("rst_out_active", int'(out_active), 0);

    in_reset_n = 1;
    wait_release(n);
    chk("release_cycles", n, 4);
    chk("active_after_release", int'(out_active), 3);
    wait_tick(0, n);
    chk("first_tick_ch0", n, 53);
    chk("clk_high_after_tick", int'(out_clk[0]), 1);
    wait_tick(0, n);
    chk("tick_period_54", n, 54);
    chk("clk_low_after_2nd_tick", int'(out_clk[0]), 0);

    // lock drop for one cycle
    cyc(10);
    in_locked = 0;
    cyc(1);
    in_locked = 1;
    chk("lockdrop_reset", int'(out_reset), 1);
    chk("lockdrop_clk", int'(out_clk), 0);
    chk("lockdrop_active", int'(out_active), 0);
    wait_release(n);
    chk("relock_cycles", n, 4);
    wait_tick(0, n);
    chk("first_tick_after_relock", n, 53);

    // ch0 retarget to 20 at counter 5: old period completes at 54
    cyc(6);
    cfg_wr(0, 20, 0, 1);
    wait_tick(0, n);
    chk("retarget_old_period", n, 47);
    wait_tick(0, n);
    chk("retarget_new_period_a", n, 20);
    wait_tick(0, n);
    chk("retarget_new_period_b", n, 20);

    // ch1 div=10 frac=8 -> 10,11,10,11 ...
    wait_tick(1, n);
    cyc(3);
    cfg_wr(1, 10, 8, 1);
    wait_tick(1, n);
    chk("ch1_old_period", n, 50);
    sum = 0;
    for (int k = 0; k < 16; k++) begin
      wait_tick(1, n);
      chk("ch1_frac_interval", n, (k % 2 == 0) ? 10 : 11);
      sum += n;
    end
    chk("ch1_span16", sum, 168);

    // ch0 disable mid-period, then div=1
    wait_tick(0, n);
    cyc(7);
    cfg_wr(0, 20, 0, 0);
    chk("disable_active", int'(out_active[0]), 0);
    chk("disable_clk", int'(out_clk[0]), 0);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      cyc(1);
      if (out_tick[0]) cnt++;
    end
    chk("disabled_no_ticks", cnt, 0);
    cfg_wr(0, 1, 0, 1);
    chk("div1_active", int'(out_active[0]), 1);
    chk("div1_tick", int'(out_tick[0]), 1);
    for (int k = 0; k < 8; k++) begin
      c0 = out_clk[0];
      cyc(1);
      chk("div1_tick_held", int'(out_tick[0]), 1);
      chk("div1_clk_toggle", int'(out_clk[0]), int'(!c0));
    end

    // out-of-range channel, then a write while in reset
    chk("ready_before_ch3", int'(cfg_ready), 1);
    cfg_wr(3, 5, 0, 0);
    cyc(2);
    chk("ch3_no_change", int'(out_active), 3);
    in_locked = 0;
    cyc(1);
    cfg_valid = 1; cfg_ch = 2'd1; cfg_div = '0; cfg_frac = '0; cfg_enable = 0;
    cyc(2);
    chk("ready_in_reset", int'(cfg_ready), 0);
    cfg_valid = 0;
    in_locked = 1;
    cyc(6);
    chk("write_in_reset_ignored", int'(out_active), 3);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 99) < 6) begin
        cfg_valid = 1;
        cfg_ch = CHW'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
          0:       cfg_div = '0;
          1:       cfg_div = DW'(1);
          2:       cfg_div = DW'(2);
          default: cfg_div = DW'($urandom_range(1, 15));
        endcase
        cfg_frac = FW'($urandom_range(0, 15));
        cfg_enable = ($urandom_range(0, 5) != 0);
      end else begin
        cfg_valid = 0;
      end
      in_locked = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 999) == 0) begin
        #2 in_reset_n = 0;
        cyc(1);
        #2 in_reset_n = 1;
      end
      cyc(1);
    end
    cfg_valid = 0;
    in_locked = 1;
    cyc(2);
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
